// File: rtl/yol_uzunlugu_olcer.sv
// yol_uzunlugu_olcer
//
// Sequential road-length measurement front-end. After a start pulse it
// counts distance ticks on the stony road, then on the asphalt road, each
// road being closed by an end-of-road marker. It then presents the
// results with a valid/acknowledge handshake.
//
// Ports
//   clk                  system clock, rising edge
//   rst_n                synchronous active-low reset
//   basla                start pulse, honoured only in BOSTA
//   tik                  one distance unit travelled this cycle
//   bitti                end of the current road
//   onay                 consumer accepts the presented result
//   tasli_yol_uzunlugu   1 when the stony count >= TASLI_ESIK
//   asfalt_yol_uzunlugu  asphalt tick count, saturating at 7
//   gecerli              result valid
//   mesgul               busy, high while state != BOSTA
//
// state      | meaning
// -----------+------------------------------------------------
// BOSTA      | idle; the previous result is held on the outputs
// TASLI_OLC  | counting stony-road ticks
// ASFALT_OLC | counting asphalt-road ticks
// SONUC      | result presented, waiting for onay

module yol_uzunlugu_olcer #(
    parameter int TASLI_ESIK = 4,
    parameter int TASLI_GEN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       basla,
    input  logic       tik,
    input  logic       bitti,
    input  logic       onay,
    output logic       tasli_yol_uzunlugu,
    output logic [2:0] asfalt_yol_uzunlugu,
    output logic       gecerli,
    output logic       mesgul
);

    typedef enum logic [1:0] {
        BOSTA      = 2'd0,
        TASLI_OLC  = 2'd1,
        ASFALT_OLC = 2'd2,
        SONUC      = 2'd3
    } durum_t;

    localparam logic [TASLI_GEN-1:0] TASLI_MAX = '1;
    localparam logic [TASLI_GEN-1:0] TASLI_BIR = TASLI_GEN'(1);
    localparam logic [TASLI_GEN-1:0] ESIK      = TASLI_GEN'(TASLI_ESIK);

    durum_t               durum, durum_d;
    logic [TASLI_GEN-1:0] tasli_sayac, tasli_sayac_d;
    logic [2:0]           asfalt_sayac, asfalt_sayac_d;
    logic                 tasli_cikis_d;
    logic [2:0]           asfalt_cikis_d;
    logic                 gecerli_d;
    logic                 mesgul_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum               <= BOSTA;
            tasli_sayac         <= '0;
            asfalt_sayac        <= '0;
            tasli_yol_uzunlugu  <= 1'b0;
            asfalt_yol_uzunlugu <= 3'd0;
            gecerli             <= 1'b0;
            mesgul              <= 1'b0;
        end else begin
            durum               <= durum_d;
            tasli_sayac         <= tasli_sayac_d;
            asfalt_sayac        <= asfalt_sayac_d;
            tasli_yol_uzunlugu  <= tasli_cikis_d;
            asfalt_yol_uzunlugu <= asfalt_cikis_d;
            gecerli             <= gecerli_d;
            mesgul              <= mesgul_d;
        end
    end

    always_comb begin
        durum_d        = durum;
        tasli_sayac_d  = tasli_sayac;
        asfalt_sayac_d = asfalt_sayac;
        tasli_cikis_d  = tasli_yol_uzunlugu;
        asfalt_cikis_d = asfalt_yol_uzunlugu;

        case (durum)
            BOSTA: begin
                // A tik arriving together with basla belongs to no road.
                if (basla) begin
                    tasli_sayac_d  = '0;
                    asfalt_sayac_d = 3'd0;
                    durum_d        = TASLI_OLC;
                end
            end
            TASLI_OLC: begin
                if (tik && (tasli_sayac != TASLI_MAX)) begin
                    tasli_sayac_d = tasli_sayac + TASLI_BIR;
                end
                if (bitti) begin
                    durum_d = ASFALT_OLC;
                end
            end
            ASFALT_OLC: begin
                if (tik && (asfalt_sayac != 3'd7)) begin
                    asfalt_sayac_d = asfalt_sayac + 3'd1;
                end
                // The outputs take the count including a tik that coincides with bitti.
                if (bitti) begin
                    durum_d        = SONUC;
                    tasli_cikis_d  = (tasli_sayac >= ESIK);
                    asfalt_cikis_d = asfalt_sayac_d;
                end
            end
            SONUC: begin
                if (onay) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase

        // Flags follow the next state so they change on the same edge as the state.
        gecerli_d = (durum_d == SONUC);
        mesgul_d  = (durum_d != BOSTA);
    end

endmodule

// File: tb/tb_yol_uzunlugu_olcer.sv
module tb_yol_uzunlugu_olcer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       basla;
    logic       tik;
    logic       bitti;
    logic       onay;
    logic       tasli_yol_uzunlugu;
    logic [2:0] asfalt_yol_uzunlugu;
    logic       gecerli;
    logic       mesgul;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       t;
        logic [2:0] a;
    } sonuc_t;

    sonuc_t sb[$];

    yol_uzunlugu_olcer #(.TASLI_ESIK(4), .TASLI_GEN(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .basla               (basla),
        .tik                 (tik),
        .bitti               (bitti),
        .onay                (onay),
        .tasli_yol_uzunlugu  (tasli_yol_uzunlugu),
        .asfalt_yol_uzunlugu (asfalt_yol_uzunlugu),
        .gecerli             (gecerli),
        .mesgul              (mesgul)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one measurement up to and including the asphalt bitti and
    // pushes the expected result derived from the applied stimulus.
    task automatic start_and_count(input int ns, input int na, input bit tik_with_basla,
                                   input bit tik_b1, input bit tik_b2, input bit abuse);
        int     st;
        int     as_;
        sonuc_t e;
        st   = ns + int'(tik_b1);
        as_  = na + int'(tik_b2);
        if (st > 15) st = 15;
        if (as_ > 7) as_ = 7;
        e.t  = (st >= 4);
        e.a  = 3'(as_);
        sb.push_back(e);

        basla = 1'b1; tik = tik_with_basla; cyc(); basla = 1'b0; tik = 1'b0;
        checks++;
        if (mesgul !== 1'b1) begin
            errors++;
            $display("FAIL mesgul_after_basla: got %b want 1", mesgul);
        end
        for (int i = 0; i < ns; i++) begin
            tik = 1'b1; basla = abuse && (i == 0); cyc(); tik = 1'b0; basla = 1'b0;
        end
        bitti = 1'b1; tik = tik_b1; cyc(); bitti = 1'b0; tik = 1'b0;
        for (int i = 0; i < na; i++) begin
            tik = 1'b1; onay = abuse && (i == 0); cyc(); tik = 1'b0; onay = 1'b0;
        end
        if (abuse) begin
            onay = 1'b1; basla = 1'b1; cyc(); onay = 1'b0; basla = 1'b0;
        end
        checks++;
        if (gecerli !== 1'b0 || mesgul !== 1'b1) begin
            errors++;
            $display("FAIL early_valid: got gecerli=%b mesgul=%b want 0 1", gecerli, mesgul);
        end
        bitti = 1'b1; tik = tik_b2; cyc(); bitti = 1'b0; tik = 1'b0;
        checks++;
        if (gecerli !== 1'b1) begin
            errors++;
            $display("FAIL valid_latency: got gecerli=%b want 1", gecerli);
        end
    endtask

    task automatic finish_txn(input int onay_delay);
        sonuc_t e;
        int     n;
        n = 0;
        while (gecerli !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL wait_valid: got timeout after %0d cycles want gecerli=1", n);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (tasli_yol_uzunlugu !== e.t || asfalt_yol_uzunlugu !== e.a) begin
            errors++;
            $display("FAIL result: got tasli=%b asfalt=%0d want tasli=%b asfalt=%0d",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, e.t, e.a);
        end
        for (int d = 0; d < onay_delay; d++) begin
            cyc();
            checks++;
            if (gecerli !== 1'b1 || tasli_yol_uzunlugu !== e.t || asfalt_yol_uzunlugu !== e.a) begin
                errors++;
                $display("FAIL hold: got gecerli=%b tasli=%b asfalt=%0d want 1 %b %0d",
                         gecerli, tasli_yol_uzunlugu, asfalt_yol_uzunlugu, e.t, e.a);
            end
        end
        onay = 1'b1; cyc(); onay = 1'b0;
        checks++;
        if (gecerli !== 1'b0 || mesgul !== 1'b0 ||
            tasli_yol_uzunlugu !== e.t || asfalt_yol_uzunlugu !== e.a) begin
            errors++;
            $display("FAIL release: got gecerli=%b mesgul=%b tasli=%b asfalt=%0d want 0 0 %b %0d",
                     gecerli, mesgul, tasli_yol_uzunlugu, asfalt_yol_uzunlugu, e.t, e.a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; basla = 1'b0; tik = 1'b0; bitti = 1'b0; onay = 1'b0;
        cyc(); cyc();
        checks++;
        if ({tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b%b%b%b want 000000",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul);
        end
        rst_n = 1'b1; cyc(); cyc();
        checks++;
        if ({tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL idle_state: got %b%b%b%b want 000000",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul);
        end
    endtask

    task automatic test_nominal();
        start_and_count(5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(2);
    endtask

    task automatic test_saturation();
        start_and_count(20, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(0);
        start_and_count(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(1);
        start_and_count(4, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(0);
    endtask

    task automatic test_simultaneous();
        start_and_count(3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        finish_txn(0);
        start_and_count(3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_txn(0);
    endtask

    task automatic test_reset_mid();
        sonuc_t e;
        basla = 1'b1; cyc(); basla = 1'b0;
        bitti = 1'b1; cyc(); bitti = 1'b0;
        tik = 1'b1; cyc(); cyc(); tik = 1'b0;
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        checks++;
        if ({tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL reset_in_asfalt: got %b%b%b%b want 000000",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul);
        end
        start_and_count(6, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (tasli_yol_uzunlugu !== e.t || asfalt_yol_uzunlugu !== e.a) begin
            errors++;
            $display("FAIL result_before_reset: got tasli=%b asfalt=%0d want %b %0d",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, e.t, e.a);
        end
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        checks++;
        if ({tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul} !== 6'b0) begin
            errors++;
            $display("FAIL reset_in_sonuc: got %b%b%b%b want 000000",
                     tasli_yol_uzunlugu, asfalt_yol_uzunlugu, gecerli, mesgul);
        end
        start_and_count(2, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(1);
    endtask

    task automatic test_abuse();
        start_and_count(5, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_txn(2);
    endtask

    task automatic test_back_to_back();
        start_and_count(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(0);
        start_and_count(7, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_txn(0);
        start_and_count(1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_txn(0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_simultaneous();
        test_reset_mid();
        test_abuse();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yol_uzunlugu_olcer.md
Name: yol_uzunlugu_olcer

Overview:
- Sequential measurement front-end that produces the road-length inputs consumed by the route-selection logic (`tasli_yol_uzunlugu`, `asfalt_yol_uzunlugu[2:0]`).
- Measures the stony road, then the asphalt road, by counting distance ticks between a start command and end-of-road markers.
- Presents both lengths with a valid/acknowledge handshake, held stable until the consumer accepts them.

Parameters:
- TASLI_ESIK, 4: stony-road tick count at or above which `tasli_yol_uzunlugu` = 1 (legal range 1..15).
- TASLI_GEN, 4: width of the internal stony-road counter; saturates at 2^TASLI_GEN-1.

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- basla  input  1  start-measurement pulse; honoured only in BOSTA
- tik  input  1  one distance unit travelled this cycle
- bitti  input  1  end-of-current-road marker
- onay  input  1  consumer accepts presented result
- tasli_yol_uzunlugu  output  1  1 when stony count >= TASLI_ESIK
- asfalt_yol_uzunlugu  output  3  asphalt tick count, saturating at 7
- gecerli  output  1  result valid
- mesgul  output  1  high in TASLI_OLC, ASFALT_OLC or SONUC

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - state = BOSTA; both counters = 0.
  - `tasli_yol_uzunlugu` = 0, `asfalt_yol_uzunlugu` = 3'b000, `gecerli` = 0, `mesgul` = 0.
  - Reset overrides every other input, including mid-measurement and while `gecerli` = 1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- BOSTA:
  - `basla` = 1 clears both counters and moves to TASLI_OLC next cycle.
  - A `tik` or `bitti` in the same cycle as `basla` is ignored.
  - Previous result outputs hold their values in BOSTA.
- TASLI_OLC:
  - Each cycle with `tik` = 1 increments the stony counter, saturating at 15 (no wrap).
  - `bitti` = 1 moves to ASFALT_OLC. A `tik` in the same cycle as `bitti` is counted to the stony road.
- ASFALT_OLC:
  - Each `tik` increments the 3-bit asphalt counter, saturating at 7 (no wrap to 0).
  - `bitti` = 1 moves to SONUC. A simultaneous `tik` is counted, subject to saturation.
  - On that transition edge the outputs are loaded from the final counts: `tasli_yol_uzunlugu` = (stony >= TASLI_ESIK), `asfalt_yol_uzunlugu` = asphalt count.
  - `gecerli` = 1 from the cycle following the transition edge, i.e. the first cycle in SONUC.
- SONUC:
  - Outputs and `gecerli` are held stable while `onay` = 0.
  - `onay` = 1 returns to BOSTA; `gecerli` = 0 the next cycle, data outputs keep their values.
  - `onay` sampled in any state other than SONUC is ignored.
- `basla` outside BOSTA is ignored; it does not restart the measurement.
- `mesgul` is registered with the state: 1 exactly while state != BOSTA.
- Latency:
  - `basla` at cycle N → counting from N+1.
  - `bitti` in ASFALT_OLC at cycle M → `gecerli` = 1 at cycle M+1.
- Minimum transaction: `basla`, `bitti`, `bitti`, `onay` on consecutive cycles → back in BOSTA 4 cycles after `basla`.
- A new `basla` is accepted in the first cycle after returning to BOSTA.

Test Plan:
1. Reset then idle: `rst_n` = 0 for 2 cycles, `basla` = 0 → all outputs 0, `mesgul` = 0.
2. Nominal run: `basla`; 5 `tik`, `bitti`; 3 `tik`, `bitti`; `onay` after 2 cycles → `tasli` = 1, `asfalt` = 3'd3, `gecerli` high for exactly 3 cycles, then 0 with data held.
3. Saturation: 20 stony ticks, 10 asphalt ticks → `tasli` = 1, `asfalt` = 3'd7 (no wrap to 3'd2); 3 stony ticks and TASLI_ESIK = 4 → `tasli` = 0.
4. Simultaneous events: `tik` with `bitti` on both roads (stony 3+1, asphalt 0+1) → `tasli` = 1, `asfalt` = 3'd1; `basla` asserted together with `tik` in BOSTA → that tick is not counted.
5. Reset mid-operation: `rst_n` = 0 in ASFALT_OLC after 2 ticks, and again while `gecerli` = 1 → next cycle state BOSTA, outputs 0, `gecerli` 0; a fresh run completes correctly.
6. Protocol abuse: `basla` during TASLI_OLC and `onay` during ASFALT_OLC → no restart, no early return; the result equals the undisturbed run.
